// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, PC-tagged results buffered in a DEPTH-entry FIFO toward decode.
// Request issued the cycle after fetch_pc is sampled; response visible at instr_* next cycle; issue stalls while FIFO is full.
module fetch_unit #(
  parameter int          DEPTH       = 2,
  parameter logic [31:0] FAULT_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_pc,
  input  logic        flush,
  output logic        pc_advance,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_fault
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FAULT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic            discard_q, discard_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     ins_q [DEPTH];
  logic [31:0]     pcs_q [DEPTH];
  logic            flt_q [DEPTH];

  logic            push, pop, full;
  logic [31:0]     push_ins, push_pc;
  logic            push_flt;

  assign full           = (count_q == CW'(DEPTH));
  assign instr_valid    = (count_q != '0);
  assign pop            = instr_valid & instr_ready;
  assign imem_req_addr  = addr_q;
  assign instr_out      = instr_valid ? ins_q[rd_ptr_q] : '0;
  assign instr_pc       = instr_valid ? pcs_q[rd_ptr_q] : '0;
  assign instr_fault    = instr_valid ? flt_q[rd_ptr_q] : 1'b0;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    discard_d      = discard_q;
    pc_advance     = 1'b0;
    imem_req_valid = 1'b0;
    push           = 1'b0;
    push_ins       = '0;
    push_pc        = '0;
    push_flt       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && !full) begin
          if (fetch_pc[1:0] == 2'b00) begin
            addr_d  = fetch_pc;
            state_d = REQ;
          end else begin
            push     = 1'b1;
            push_ins = FAULT_INSTR;
            push_pc  = fetch_pc;
            push_flt = 1'b1;
            state_d  = FAULT;
          end
        end
      end
      REQ: begin
        imem_req_valid = 1'b1;
        if (flush) discard_d = 1'b1;
        if (imem_req_ready) begin
          state_d    = WAIT;
          pc_advance = !flush && !discard_q;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          // A response racing a flush belongs to the old path and is dropped.
          if (!discard_q && !flush) begin
            push     = 1'b1;
            push_ins = imem_resp_data;
            push_pc  = addr_q;
          end
          discard_d = 1'b0;
          state_d   = IDLE;
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      FAULT: begin
        if (flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Single outstanding request issued only when not full, so push never overflows.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      discard_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ins_q[i] <= '0;
        pcs_q[i] <= '0;
        flt_q[i] <= 1'b0;
      end
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      if (push && !flush) begin
        ins_q[wr_ptr_q] <= push_ins;
        pcs_q[wr_ptr_q] <= push_pc;
        flt_q[wr_ptr_q] <= push_flt;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Random PC-register/memory/decode environment around fetch_unit, checked every cycle against a queue-based model.
module tb_fetch_unit;

  localparam int          DEPTH       = 2;
  localparam logic [31:0] FAULT_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, flush, imem_req_ready, imem_resp_valid, instr_ready;
  logic [31:0] fetch_pc, imem_resp_data;
  logic        pc_advance, imem_req_valid, instr_valid, instr_fault;
  logic [31:0] imem_req_addr, instr_out, instr_pc;

  fetch_unit #(.DEPTH(DEPTH), .FAULT_INSTR(FAULT_INSTR)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .flush(flush),
    .pc_advance(pc_advance), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_fault(instr_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        flt;
  } ent_t;

  // Reference view: decode-side queue plus the request lifecycle as flags.
  ent_t        mq[$];
  bit          m_pend, m_out, m_flt, m_disc;
  logic [31:0] m_addr;
  logic [31:0] pc;
  bit          stall;
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend = 0; m_out = 0; m_flt = 0; m_disc = 0;
    m_addr = '0;
  endtask

  task automatic check_zero();
    check_val("rst_pc_advance", pc_advance, 0);
    check_val("rst_req_valid", imem_req_valid, 0);
    check_val("rst_req_addr", imem_req_addr, 0);
    check_val("rst_instr_valid", instr_valid, 0);
    check_val("rst_instr_out", instr_out, 0);
    check_val("rst_instr_pc", instr_pc, 0);
    check_val("rst_instr_fault", instr_fault, 0);
  endtask

  task automatic check_outputs(output bit adv);
    ent_t h;
    adv = m_pend && imem_req_ready && !flush && !m_disc;
    h = '{ins: '0, pc: '0, flt: 1'b0};
    if (mq.size() != 0) h = mq[0];
    check_val("pc_advance", pc_advance, adv);
    check_val("req_valid", imem_req_valid, m_pend);
    check_val("req_addr", imem_req_addr, m_addr);
    check_val("instr_valid", instr_valid, mq.size() != 0);
    check_val("instr_out", instr_out, h.ins);
    check_val("instr_pc", instr_pc, h.pc);
    check_val("instr_fault", instr_fault, h.flt);
  endtask

  task automatic model_step(input bit adv);
    bit   pop, do_push;
    ent_t e;
    pop     = (mq.size() != 0) && instr_ready;
    do_push = 0;
    e       = '{ins: '0, pc: '0, flt: 1'b0};
    if (m_pend) begin
      if (flush) m_disc = 1;
      if (imem_req_ready) begin m_pend = 0; m_out = 1; end
    end else if (m_out) begin
      if (imem_resp_valid) begin
        if (!m_disc && !flush) begin
          do_push = 1;
          e = '{ins: mem_word(m_addr), pc: m_addr, flt: 1'b0};
        end
        m_disc = 0;
        m_out  = 0;
      end else if (flush) begin
        m_disc = 1;
      end
    end else if (m_flt) begin
      if (flush) m_flt = 0;
    end else if (!flush && mq.size() < DEPTH) begin
      if (pc[1:0] == 2'b00) begin
        m_pend = 1;
        m_addr = pc;
      end else begin
        do_push = 1;
        e = '{ins: FAULT_INSTR, pc: pc, flt: 1'b1};
        m_flt = 1;
      end
    end
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    // PC register: redirect on flush, sequential step on pc_advance.
    if (flush) begin
      if ($urandom % 5 == 0) pc = 32'($urandom_range(0, 1023));
      else pc = 32'($urandom_range(0, 255)) << 2;
    end else if (adv) begin
      pc = pc + 32'd4;
    end
  endtask

  initial begin
    bit adv;
    reset = 1; flush = 0; imem_req_ready = 0; imem_resp_valid = 0;
    imem_resp_data = '0; instr_ready = 0; fetch_pc = '0; pc = '0; stall = 0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      reset = 0;
      if (cyc % 40 == 0) stall = ($urandom % 2 == 0);
      flush          = ($urandom % 14 == 0);
      imem_req_ready = ($urandom % 3 != 0);
      instr_ready    = stall ? ($urandom % 8 == 0) : ($urandom % 4 != 0);
      if (m_out) imem_resp_valid = ($urandom % 2 == 0);
      else if (!m_pend && !m_flt) imem_resp_valid = ($urandom % 16 == 0);
      else imem_resp_valid = 0;
      imem_resp_data = m_out ? mem_word(m_addr) : $urandom;
      fetch_pc = pc;
      #1;
      check_outputs(adv);
      if (m_out && ($urandom % 60 == 0)) begin
        reset = 1;
        #1;
        check_zero();
        model_reset();
        pc = 32'($urandom_range(0, 255)) << 2;
        @(posedge clk);
        continue;
      end
      @(posedge clk);
      model_step(adv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Samples the current PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Buffers returned instructions, tagged with their PC, in a small FIFO toward decode.
- Pulses pc_advance so the PC register loads its next value. Supports flush on redirect and misaligned-PC fault reporting.

Parameters:
DEPTH, 2, output FIFO entries; power of 2, minimum 2
FAULT_INSTR, 32'h00000013, instruction word emitted with a fault entry (ADDI x0,x0,0 NOP)

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-high; clears all state
fetch_pc  in  32  current PC from the PC register
flush  in  1  redirect: discard buffered and in-flight instructions
pc_advance  out  1  one-cycle pulse; PC register loads its next PC this edge
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  request word address, registered
imem_resp_valid  in  1  response valid, one cycle, no backpressure
imem_resp_data  in  32  instruction word
instr_valid  out  1  FIFO head valid toward decode
instr_ready  in  1  decode consumes head
instr_out  out  32  head instruction
instr_pc  out  32  PC of head instruction
instr_fault  out  1  head is a misaligned-fetch fault entry

Behaviour:
- Reset (async assert):
  - State IDLE; FIFO empty; discard=0.
  - imem_req_valid=0, imem_req_addr=0, pc_advance=0.
  - instr_valid=0, instr_out=0, instr_pc=0, instr_fault=0.
- FSM states: IDLE, REQ, WAIT, FAULT.
- IDLE:
  - If flush: stay.
  - Else if FIFO count < DEPTH and fetch_pc[1:0]==0: latch imem_req_addr=fetch_pc and req_pc=fetch_pc; go to REQ.
  - Else if count < DEPTH and fetch_pc[1:0]!=0: push {FAULT_INSTR, fetch_pc, fault=1}; go to FAULT. No memory request, no pc_advance.
  - Else (FIFO full): stay.
- REQ:
  - imem_req_valid=1; imem_req_addr held stable until accepted, even if flush.
  - On valid&ready: go to WAIT; pc_advance=1 that cycle unless flush is also asserted that cycle or discard is set.
  - Flush while in REQ sets discard=1.
- WAIT:
  - On imem_resp_valid with discard=0 and no flush: push {imem_resp_data, req_pc, fault=0}.
  - On imem_resp_valid, always: clear discard and go to IDLE.
  - Flush without response: set discard=1, stay.
  - Flush together with response: response dropped.
- FAULT: stay until flush, then go to IDLE. Only flush exits.
- Issue rule: a request starts only if count < DEPTH. With a single outstanding request this guarantees the response always has space, so no overflow check is needed on push.
- FIFO:
  - Push and pop take effect at the clock edge; outputs reflect the head.
  - instr_valid = count!=0; a pop occurs when instr_valid&instr_ready.
  - Pop on empty is ignored.
  - Simultaneous push and pop: count unchanged.
  - Pointers wrap modulo DEPTH.
  - Flush empties the FIFO (count=0, pointers reset) and overrides any same-cycle push or pop.
- Latency:
  - fetch_pc sampled at edge t; imem_req_valid high from t+1.
  - Response at cycle r gives instr_valid high from r+1.
  - Minimum 3 cycles per instruction with zero-wait memory (IDLE→REQ→WAIT).
- pc_advance is never asserted in IDLE, WAIT, FAULT, or during reset.
- Reset mid-transaction: the outstanding request is abandoned. The memory side must tolerate a dropped response; any response arriving after reset in IDLE is ignored.

Test Plan:
- Reset, fetch_pc=0x00, ready=1, response 1 cycle after accept with 0x00500093 → pc_advance one pulse; instr_valid, instr_out=0x00500093, instr_pc=0x00.
- instr_ready=0, PC stepping 0x00,0x04,0x08 → exactly 2 entries buffered; no request issued while full. Then instr_ready=1 → entries pop in order (0x00, 0x04), then fetch of 0x08 resumes.
- imem_req_ready low for 3 cycles with fetch_pc=0x10 → imem_req_addr stays 0x10 throughout; single pc_advance on accept.
- Flush asserted in WAIT before response for 0x20 → response dropped; FIFO empty; next request uses the new fetch_pc=0x100.
- Flush coincident with handshake in REQ → pc_advance=0; following response discarded.
- fetch_pc=0x06 → instr_fault=1, instr_out=0x00000013, instr_pc=0x06; no imem request until flush; async reset mid-WAIT → all outputs 0 immediately.
